// File: rtl/char_window_scanner.sv
// char_window_scanner
// Pixel-side consumer of the character window. Decides window membership for
// the live pixel (including windows wrapping past the right or bottom edge),
// tracks glyph column/row indices at scale s, issues character-ROM reads and
// merges the returned glyph bit into a 9-bit RGB pixel.
// Two-cycle latency: stage 1 = readEn/colCnt/rowCnt, stage 2 = vgaRGB.
// Optional macro FRAME_LATCH_EN: window bounds and charSize are shadowed once
// per frame (at the first active pixel and on reset) so mid-frame changes
// never tear a glyph. Without it the inputs are used live.

module char_window_scanner #(
  parameter int         HDR    = 640,
  parameter int         VDR    = 480,
  parameter int         HAL    = 8,
  parameter int         VAL    = 16,
  parameter logic [8:0] FG_RGB = 9'h1FF,
  parameter logic [8:0] BG_RGB = 9'h000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               hCount,
  input  logic [8:0]               vCount,
  input  logic                     displayEn,
  input  logic [2:0]               charSize,
  input  logic [9:0]               posHorStart,
  input  logic [9:0]               posHorEnd,
  input  logic [8:0]               posVerStart,
  input  logic [8:0]               posVerEnd,
  input  logic                     romBit,
  output logic                     readEn,
  output logic [$clog2(HAL)-1:0]   colCnt,
  output logic [$clog2(VAL)-1:0]   rowCnt,
  output logic [8:0]               vgaRGB
);

  localparam int              CW       = $clog2(HAL);
  localparam int              RW       = $clog2(VAL);
  localparam logic [9:0]      H_LAST   = 10'(HDR - 1);
  localparam logic [9:0]      H_LIM    = 10'(HDR);
  localparam logic [8:0]      V_LIM    = 9'(VDR);
  localparam logic [CW-1:0]   COL_LAST = CW'(HAL - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(VAL - 1);

  // Inclusive span test; lo > hi means the span wraps through zero.
  function automatic logic in_span(input logic [9:0] p,
                                   input logic [9:0] lo,
                                   input logic [9:0] hi);
    if (lo <= hi) in_span = (p >= lo) && (p <= hi);
    else          in_span = (p >= lo) || (p <= hi);
  endfunction

  // Effective window bounds and scale (shadowed or live)
  logic [9:0] hs_e, he_e;
  logic [8:0] vs_e, ve_e;
  logic [2:0] cs_e;

`ifdef FRAME_LATCH_EN
  logic [9:0] hs_q, he_q;
  logic [8:0] vs_q, ve_q;
  logic [2:0] cs_q;
  logic       frame_top;

  assign frame_top = displayEn && (hCount == 10'd0) && (vCount == 9'd0);

  // Capture the window once per frame so a mid-frame change waits for the next frame
  always_ff @(posedge clk) begin
    if (reset || frame_top) begin
      hs_q <= posHorStart;
      he_q <= posHorEnd;
      vs_q <= posVerStart;
      ve_q <= posVerEnd;
      cs_q <= charSize;
    end
  end

  // The frame-top pixel itself already sees the freshly captured bounds
  always_comb begin
    hs_e = frame_top ? posHorStart : hs_q;
    he_e = frame_top ? posHorEnd   : he_q;
    vs_e = frame_top ? posVerStart : vs_q;
    ve_e = frame_top ? posVerEnd   : ve_q;
    cs_e = frame_top ? charSize    : cs_q;
  end
`else
  // Live bounds every cycle
  always_comb begin
    hs_e = posHorStart;
    he_e = posHorEnd;
    vs_e = posVerStart;
    ve_e = posVerEnd;
    cs_e = charSize;
  end
`endif

  logic [2:0]    hsub_q, hsub_d, hsub_pix;
  logic [2:0]    vsub_q, vsub_d, vsub_pix;
  logic [CW-1:0] col_q, col_d, col_pix;
  logic [RW-1:0] row_q, row_d, row_pix;
  logic [2:0]    s_m1;
  logic          act, h_in, v_in, in_win;
  logic          col_clr, row_clr, row_inc;

  logic          rd_en_q;
  logic [CW-1:0] col_out_q;
  logic [RW-1:0] row_out_q;
  logic [8:0]    rgb_q;

  // Membership, counter values for the current pixel and next-state counters.
  // A clear gives the current pixel index 0; counting then advances from there.
  always_comb begin
    s_m1     = (cs_e == 3'd0) ? 3'd0 : cs_e - 3'd1;
    act      = displayEn && (hCount < H_LIM) && (vCount < V_LIM);
    h_in     = in_span(hCount, hs_e, he_e);
    v_in     = in_span({1'b0, vCount}, {1'b0, vs_e}, {1'b0, ve_e});
    in_win   = act && h_in && v_in;
    col_clr  = act && (hCount == hs_e);
    row_clr  = act && (hCount == 10'd0) && (vCount == vs_e);
    row_inc  = act && (hCount == H_LAST) && v_in;

    hsub_pix = col_clr ? 3'd0 : hsub_q;
    col_pix  = col_clr ? '0   : col_q;
    vsub_pix = row_clr ? 3'd0 : vsub_q;
    row_pix  = row_clr ? '0   : row_q;

    hsub_d   = hsub_pix;
    col_d    = col_pix;
    vsub_d   = vsub_pix;
    row_d    = row_pix;

    if (in_win) begin
      if (hsub_pix >= s_m1) begin
        hsub_d = 3'd0;
        col_d  = (col_pix == COL_LAST) ? '0 : col_pix + 1'b1;
      end else begin
        hsub_d = hsub_pix + 3'd1;
      end
    end

    if (row_inc && !row_clr) begin
      if (vsub_pix >= s_m1) begin
        vsub_d = 3'd0;
        row_d  = (row_pix == ROW_LAST) ? '0 : row_pix + 1'b1;
      end else begin
        vsub_d = vsub_pix + 3'd1;
      end
    end
  end

  // Counter state and stage-1 outputs (ROM strobe and glyph indices)
  always_ff @(posedge clk) begin
    if (reset) begin
      hsub_q    <= 3'd0;
      vsub_q    <= 3'd0;
      col_q     <= '0;
      row_q     <= '0;
      rd_en_q   <= 1'b0;
      col_out_q <= '0;
      row_out_q <= '0;
    end else begin
      hsub_q    <= hsub_d;
      vsub_q    <= vsub_d;
      col_q     <= col_d;
      row_q     <= row_d;
      rd_en_q   <= in_win;
      col_out_q <= col_pix;
      row_out_q <= row_pix;
    end
  end

  // Stage 2: merge the glyph bit returned one cycle after the read strobe
  always_ff @(posedge clk) begin
    if (reset) rgb_q <= 9'h000;
    else       rgb_q <= rd_en_q ? (romBit ? FG_RGB : BG_RGB) : 9'h000;
  end

  assign readEn = rd_en_q;
  assign colCnt = col_out_q;
  assign rowCnt = row_out_q;
  assign vgaRGB = rgb_q;

endmodule
